// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
package sipo_deser_pkg;

  // Order in which serial bits populate the output word.
  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  // Index width for a given word width; never narrower than one bit.
  function automatic int idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_deser_wrap_counter.sv
// Modulo-N counter with synchronous reset/clear and a terminal-count flag.
module wrap_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (cnt == LAST);

  // Count up on inc, wrapping from N-1 back to 0; clear restarts the sequence.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with valid/ready output and overrun pulse.
module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int IDX_W     = idx_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun,
  output logic [IDX_W-1:0] o_idx
);

  localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST);
  localparam logic [IDX_W-1:0] TOP = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] asm_q;
  logic [WIDTH-1:0] merged;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pos;
  logic             last_bit;
  logic             sample;
  logic             complete;
  logic             load;
  logic             drop;

  // A clear in the same cycle discards the presented bit.
  assign sample   = i_en & ~i_clear;
  assign complete = sample & last_bit;
  // A completed word lands if the output slot is free or being drained now.
  assign load     = complete & (~o_valid | i_ready);
  assign drop     = complete & o_valid & ~i_ready;
  assign pos      = (ORDER == sipo_deser_pkg::MSB_FIRST) ? TOP - idx : idx;
  assign o_idx    = idx;

  wrap_counter #(.N(WIDTH), .W(IDX_W)) u_idx (
    .clk (i_clk),
    .rst (i_rst),
    .clr (i_clear),
    .inc (sample),
    .cnt (idx),
    .tc  (last_bit)
  );

  // Assembly word with the incoming bit merged, so completion sees the full word this edge.
  always_comb begin
    merged      = asm_q;
    merged[pos] = i_a;
  end

  // Assembly register keeps stale bits across words; every position is rewritten before reuse.
  always_ff @(posedge i_clk) begin
    if (i_rst)       asm_q <= '0;
    else if (sample) asm_q <= merged;
  end

  // Output slot: load on completion, release on transfer, flag dropped words for one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= drop;
      if (load) begin
        o_data  <= merged;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Randomized + directed bench: three deserializer configs against a word-level model.
module tb_sipo_deser;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst = 1'b1, i_a = 1'b0, i_en = 1'b0, i_clear = 1'b0, i_ready = 1'b0;

  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic       v0, v1, v2, o0, o1, o2;
  logic [2:0] x0, x1, x2;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_a(i_a), .i_en(i_en), .i_clear(i_clear),
    .i_ready(i_ready), .o_data(d0), .o_valid(v0), .o_overrun(o0), .o_idx(x0));

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_a(i_a), .i_en(i_en), .i_clear(i_clear),
    .i_ready(i_ready), .o_data(d1), .o_valid(v1), .o_overrun(o1), .o_idx(x1));

  sipo_deser #(.WIDTH(5), .MSB_FIRST(1'b0)) u_lsb5 (
    .i_clk(i_clk), .i_rst(i_rst), .i_a(i_a), .i_en(i_en), .i_clear(i_clear),
    .i_ready(i_ready), .o_data(d2), .o_valid(v2), .o_overrun(o2), .o_idx(x2));

  int n_chk = 0;
  int n_pass = 0;

  // Reference: bits collected since frame start, placed by arrival order.
  int          mw[3] = '{8, 8, 5};
  bit          mm[3] = '{1'b0, 1'b1, 1'b0};
  int          cnt[3];
  logic [63:0] acc[3];
  logic [63:0] mdata[3];
  bit          mval[3];
  bit          movr[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step();
    int          pos;
    bit          samp, comp;
    logic [63:0] nw;
    for (int k = 0; k < 3; k++) begin
      if (i_rst) begin
        cnt[k] = 0; acc[k] = '0; mdata[k] = '0; mval[k] = 0; movr[k] = 0;
      end else begin
        samp    = i_en && !i_clear;
        pos     = mm[k] ? (mw[k] - 1 - cnt[k]) : cnt[k];
        nw      = acc[k] | (64'(i_a) << pos);
        comp    = samp && (cnt[k] == mw[k] - 1);
        movr[k] = comp && mval[k] && !i_ready;
        if (comp && (!mval[k] || i_ready)) begin
          mdata[k] = nw;
          mval[k]  = 1;
        end else if (mval[k] && i_ready) begin
          mval[k] = 0;
        end
        if (i_clear) begin
          cnt[k] = 0; acc[k] = '0;
        end else if (samp) begin
          if (comp) begin cnt[k] = 0; acc[k] = '0; end
          else begin cnt[k] = cnt[k] + 1; acc[k] = nw; end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("lsb8_data", 64'(d0), mdata[0]); chk("lsb8_valid", 64'(v0), 64'(mval[0]));
    chk("lsb8_ovr",  64'(o0), 64'(movr[0])); chk("lsb8_idx", 64'(x0), 64'(cnt[0]));
    chk("msb8_data", 64'(d1), mdata[1]); chk("msb8_valid", 64'(v1), 64'(mval[1]));
    chk("msb8_ovr",  64'(o1), 64'(movr[1])); chk("msb8_idx", 64'(x1), 64'(cnt[1]));
    chk("lsb5_data", 64'(d2), mdata[2]); chk("lsb5_valid", 64'(v2), 64'(mval[2]));
    chk("lsb5_ovr",  64'(o2), 64'(movr[2])); chk("lsb5_idx", 64'(x2), 64'(cnt[2]));
  endtask

  // Inputs change 1ns after an edge; outputs are compared 1ns after the next edge.
  task automatic cyc(input bit a, input bit en, input bit clr, input bit rdy, input bit rst);
    i_a = a; i_en = en; i_clear = clr; i_ready = rdy; i_rst = rst;
    @(posedge i_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] w, input bit rdy, input bit rdy_last);
    for (int i = 0; i < 8; i++) cyc(w[i], 1'b1, 1'b0, (i == 7) ? rdy_last : rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'h4D;

    // Reset state
    cyc(0, 0, 0, 0, 1);
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_idx",   64'(x0), 64'd0);

    // Basic word in both bit orders
    send(pat, 1'b1, 1'b1);
    chk("tp_lsb_4d", 64'(d0), 64'h4D);
    chk("tp_msb_b2", 64'(d1), 64'hB2);
    chk("tp_valid",  64'(v0), 64'd1);
    chk("tp_idx0",   64'(x0), 64'd0);
    cyc(0, 0, 0, 1, 0);
    chk("tp_valid_drop", 64'(v0), 64'd0);

    // Overrun: second word dropped while stalled
    send(8'hA5, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    chk("ovr_hold", 64'(d0), 64'hA5);
    chk("ovr_pulse", 64'(o0), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("ovr_single", 64'(o0), 64'd0);
    cyc(0, 0, 0, 1, 0);
    chk("ovr_drain", 64'(v0), 64'd0);

    // Completion on the same edge as a transfer
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b1);
    chk("swap_data",  64'(d0), 64'h22);
    chk("swap_valid", 64'(v0), 64'd1);
    chk("swap_ovr",   64'(o0), 64'd0);
    cyc(0, 0, 0, 1, 0);

    // Gaps between bits give the same word
    for (int i = 0; i < 8; i++) begin
      cyc(pat[i], 1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("gap_4d", 64'(d0), 64'h4D);

    // Clear mid-word (with a bit presented), then a clean word
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_idx", 64'(x0), 64'd0);
    send(8'hFF, 1'b1, 1'b1);
    chk("clr_ff", 64'(d0), 64'hFF);

    // Clear at the last index with en: no completion
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_last_valid", 64'(v0), 64'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++)
      cyc(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(19) == 0),
          1'($urandom), ($urandom_range(99) == 0));

    // Non-power-of-two width: wrap 4->0, end at 2, then reset with a pending word
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 4) chk("w5_wrap", 64'(x2), 64'd0);
    end
    chk("w5_idx2", 64'(x2), 64'd2);
    chk("w5_pending", 64'(v2), 64'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("w5_idx3", 64'(x2), 64'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("w5_rst_valid", 64'(v2), 64'd0);
    chk("w5_rst_data",  64'(d2), 64'd0);
    chk("w5_rst_idx",   64'(x2), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserializer. It is the successor to the single-bit-write packed-array assembler.
- Collects WIDTH serial bits into a word using a bounded, wrapping bit index, with selectable bit order.
- Presents each completed word on a valid/ready output register and reports overrun.
- Sits between a serial front end (one bit per enable) and word-oriented consumers.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 0, bit order. 0: first received bit lands in o_data[0]. 1: first received bit lands in o_data[WIDTH-1].
- IDX_W, $clog2(WIDTH), width of the bit index (derived; not overridden).

Ports:
- i_clk  input  1  single clock; all state updates on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_a  input  1  serial data bit.
- i_en  input  1  i_a is valid this cycle and is sampled.
- i_clear  input  1  synchronous frame restart: index to 0, partial word discarded.
- i_ready  input  1  downstream accepts o_data when o_valid=1.
- o_data  output  WIDTH  last completed word.
- o_valid  output  1  o_data holds an unconsumed word.
- o_overrun  output  1  one-cycle pulse: completed word dropped.
- o_idx  output  IDX_W  next bit position to fill (0..WIDTH-1).

Behaviour:
- Reset (i_rst=1 at an edge):
  - idx, assembly register, o_data, o_valid and o_overrun all go to 0.
  - Reset overrides every other input.
- Sampling:
  - On an edge with i_en=1 and i_clear=0, i_a is written into the assembly register.
  - Bit position is idx when MSB_FIRST=0, and WIDTH-1-idx when MSB_FIRST=1.
  - Only that one bit changes.
  - Cycles with i_en=0 leave all assembly state unchanged.
- Index:
  - Increments by 1 per sampled bit.
  - Wraps from WIDTH-1 to 0; it never exceeds WIDTH-1.
  - Counts modulo WIDTH for any WIDTH, including non-powers of two.
- Completion:
  - A sampled bit with idx=WIDTH-1 completes the word.
  - The completed word is the assembly register merged with that bit in the same edge.
  - Latency: o_data and o_valid update at the completion edge. The word is visible in the cycle after the last bit is presented.
  - The assembly register is not cleared on completion; the next word overwrites it bit by bit.
- Handshake:
  - Transfer occurs at an edge where o_valid=1 and i_ready=1.
  - o_valid drops to 0 after a transfer unless a new word completes on the same edge.
  - o_data is held stable while o_valid=1 and no transfer has occurred.
- Simultaneous completion and transfer (o_valid=1, i_ready=1): new word loads, o_valid stays 1, no overrun.
- Overrun (completion while o_valid=1 and i_ready=0):
  - The new word is dropped; o_data and o_valid are unchanged.
  - o_overrun=1 for exactly the next cycle.
  - The index still wraps to 0.
- i_clear:
  - idx goes to 0 and the partial word is discarded.
  - A bit presented with i_en in the same cycle is discarded.
  - o_data/o_valid are unaffected, so a pending word survives a clear.
- i_clear at idx=WIDTH-1 with i_en=1: clear wins; no completion, no overrun.
- o_overrun is 0 in every cycle not immediately following an overrun edge.
- i_rst asserted mid-word or with a pending word: everything is lost; o_valid=0 the cycle after.

Decomposition:
- Package sipo_deser_pkg holds:
  - the bit-order enum (LSB_FIRST=0, MSB_FIRST=1);
  - function idx_w(width), returning $clog2(width) with a minimum of 1.
- Sub-module wrap_counter: parametrised modulo-N counter.
  - Inputs: clock, synchronous reset, clear, increment.
  - Outputs: count and a terminal-count flag.
  - Instantiated once for idx.
- The remaining logic (assembly register, output register, handshake) is inline.

Test Plan:
- WIDTH=8, MSB_FIRST=0, i_ready=1; 8 consecutive i_en bits 1,0,1,1,0,0,1,0 -> o_data=8'h4D, o_valid=1 for one cycle, o_idx back to 0.
- Same stream with MSB_FIRST=1 -> o_data=8'hB2.
- i_ready=0; send two full words 8'hA5 then 8'h3C -> o_data stays 8'hA5, o_overrun pulses once at second completion. Raise i_ready -> o_valid drops next cycle.
- o_valid=1 with 8'h11 pending, i_ready=1 on the exact completion edge of 8'h22 -> o_data=8'h22, o_valid stays 1, o_overrun=0.
- Interleaved gaps: same 8 bits with i_en=0 between each -> identical o_data; then i_clear after 5 bits, resend 8 bits of 8'hFF -> o_data=8'hFF, no stale bits.
- WIDTH=5: 12 bits -> two completions, o_idx sequence wraps 4->0 and ends at 2. i_rst at o_idx=3 with a pending word -> all outputs 0 next cycle.
